rr_sel_arbiter: RTL and testbench

RR_SEL_ARBITER -- requirements
Module: rr_sel_arbiter

---
 rtl/rr_sel_arbiter.sv | 112 +++++++++++
 tb/tb_rr_sel_arbiter.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/rr_sel_arbiter.sv
// Round-robin 5-port output arbiter with registered one-hot grant, mux select and
// packet-length guard that forces a release after MAX_PKT_LEN flits.
module rr_sel_arbiter #(
  parameter int unsigned MAX_PKT_LEN = 16
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [4:0] req_i,
  input  logic       tail_i,
  input  logic       ready_i,
  output logic [2:0] sel_o,
  output logic [4:0] grant_o,
  output logic       valid_o,
  output logic       err_o
);

  localparam int unsigned CNT_W = $clog2(MAX_PKT_LEN + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_q, state_d;
  logic [2:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [2:0]       sel_d, ptr_rel, arb_ptr;
  logic [4:0]       grant_d;
  logic             valid_d, err_d, do_arb;
  logic [3:0]       pick;

  // Returns {found, index} of the first requester scanning from ptr, wrapping 4->0.
  function automatic logic [3:0] rr_pick(input logic [4:0] req, input logic [2:0] ptr);
    logic [3:0]  r;
    int unsigned idx;
    logic [2:0]  idx3;
    r = {1'b0, 3'b111};
    for (int unsigned i = 0; i < 5; i++) begin
      idx  = (32'(ptr) + i) % 5;
      idx3 = 3'(idx);
      if (!r[3] && req[idx3]) r = {1'b1, idx3};
    end
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    sel_d   = sel_o;
    grant_d = grant_o;
    valid_d = valid_o;
    err_d   = 1'b0;
    cnt_inc = cnt_q + CNT_W'(1);
    ptr_rel = (sel_o == 3'd4) ? 3'd0 : sel_o + 3'd1;
    arb_ptr = ptr_q;
    do_arb  = 1'b0;
    pick    = '0;

    case (state_q)
      IDLE: do_arb = 1'b1;
      BUSY: begin
        if (ready_i) begin
          if (tail_i || cnt_inc == CNT_W'(MAX_PKT_LEN)) begin
            ptr_d   = ptr_rel;
            arb_ptr = ptr_rel;
            err_d   = !tail_i;
            do_arb  = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Release and re-arbitration share one cycle so back-to-back grants have no gap.
    if (do_arb) begin
      pick  = rr_pick(req_i, arb_ptr);
      cnt_d = '0;
      if (pick[3]) begin
        state_d = BUSY;
        sel_d   = pick[2:0];
        grant_d = 5'd1 << pick[2:0];
        valid_d = 1'b1;
      end else begin
        state_d = IDLE;
        sel_d   = 3'b111;
        grant_d = '0;
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      sel_o   <= 3'b111;
      grant_o <= '0;
      valid_o <= 1'b0;
      err_o   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      sel_o   <= sel_d;
      grant_o <= grant_d;
      valid_o <= valid_d;
      err_o   <= err_d;
    end
  end

endmodule

// File: tb/tb_rr_sel_arbiter.sv
// Directed scoreboard bench for rr_sel_arbiter: the driver queues the expected
// registered outputs per cycle, an independent monitor compares them mid-cycle.
module tb_rr_sel_arbiter;

  logic       clk = 1'b0;
  logic       rst_n_i;
  logic [4:0] req_i;
  logic       tail_i;
  logic       ready_i;
  logic [2:0] sel_o;
  logic [4:0] grant_o;
  logic       valid_o;
  logic       err_o;

  always #5 clk = ~clk;

  rr_sel_arbiter #(.MAX_PKT_LEN(16)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n_i),
    .req_i   (req_i),
    .tail_i  (tail_i),
    .ready_i (ready_i),
    .sel_o   (sel_o),
    .grant_o (grant_o),
    .valid_o (valid_o),
    .err_o   (err_o)
  );

  typedef struct {
    logic [2:0] sel;
    logic [4:0] grant;
    logic       valid;
    logic       err;
    string      name;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic exp_t gnt(input int unsigned p, input logic e, input string n);
    exp_t x;
    x.sel   = 3'(p);
    x.grant = 5'd1 << p;
    x.valid = 1'b1;
    x.err   = e;
    x.name  = n;
    return x;
  endfunction

  function automatic exp_t none(input string n);
    exp_t x;
    x.sel   = 3'b111;
    x.grant = 5'b00000;
    x.valid = 1'b0;
    x.err   = 1'b0;
    x.name  = n;
    return x;
  endfunction

  // Apply inputs for one edge and queue what the outputs must show after it.
  task automatic cyc(input logic rst, input logic [4:0] req, input logic tail,
                     input logic ready, input exp_t e);
    rst_n_i = rst;
    req_i   = req;
    tail_i  = tail;
    ready_i = ready;
    @(posedge clk);
    #1;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_checks++;
      if (sel_o !== e.sel || grant_o !== e.grant || valid_o !== e.valid || err_o !== e.err) begin
        n_fail++;
        $display("FAIL %s: got sel=%0d grant=%b valid=%b err=%b, want sel=%0d grant=%b valid=%b err=%b",
                 e.name, sel_o, grant_o, valid_o, err_o, e.sel, e.grant, e.valid, e.err);
      end
    end
  end

  initial begin
    rst_n_i = 1'b0;
    req_i   = '0;
    tail_i  = 1'b0;
    ready_i = 1'b0;
    @(posedge clk);
    #1;

    // Reset holds everything idle even with requests present.
    cyc(1'b0, 5'b11111, 1'b0, 1'b1, none("reset0"));
    cyc(1'b0, 5'b11111, 1'b1, 1'b1, none("reset1"));

    // First grant from ptr=0 picks S; S tail releases and L wins from ptr=2.
    cyc(1'b1, 5'b10010, 1'b0, 1'b1, gnt(1, 1'b0, "first_grant_S"));
    cyc(1'b1, 5'b10010, 1'b1, 1'b1, gnt(4, 1'b0, "b2b_L_after_S"));
    cyc(1'b1, 5'b00000, 1'b1, 1'b1, none("L_release_idle"));
    // Idle ignores tail/ready.
    cyc(1'b1, 5'b00000, 1'b1, 1'b1, none("idle_ignores_tail"));

    // All requesting, single-flit packets: strict rotation without gaps. ptr=0.
    for (int i = 0; i < 7; i++)
      cyc(1'b1, 5'b11111, 1'b1, 1'b1, gnt(i % 5, 1'b0, $sformatf("rotate_%0d", i)));
    cyc(1'b1, 5'b00000, 1'b1, 1'b1, none("rotate_drain"));

    // ptr=2: W granted, stalled 4 cycles, then release moves to E.
    cyc(1'b1, 5'b00100, 1'b0, 1'b1, gnt(2, 1'b0, "W_grant"));
    for (int i = 0; i < 4; i++)
      cyc(1'b1, 5'b11111, 1'b1, 1'b0, gnt(2, 1'b0, $sformatf("W_stall_%0d", i)));
    cyc(1'b1, 5'b01000, 1'b1, 1'b1, gnt(3, 1'b0, "E_after_W"));
    cyc(1'b1, 5'b00000, 1'b1, 1'b1, none("E_release"));

    // ptr=4: L granted, requests vanish mid-packet, grant held until tail.
    cyc(1'b1, 5'b10001, 1'b0, 1'b1, gnt(4, 1'b0, "L_grant"));
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 5'b00000, 1'b0, 1'b1, gnt(4, 1'b0, $sformatf("L_hold_%0d", i)));
    cyc(1'b1, 5'b00000, 1'b1, 1'b1, none("L_tail_idle"));

    // ptr=0: W granted, 16 accepts without tail force release; stalls do not count.
    cyc(1'b1, 5'b00100, 1'b0, 1'b1, gnt(2, 1'b0, "W_long_grant"));
    for (int i = 1; i <= 15; i++) begin
      cyc(1'b1, 5'b00101, 1'b0, 1'b1, gnt(2, 1'b0, $sformatf("W_long_acc_%0d", i)));
      if (i == 5) begin
        cyc(1'b1, 5'b00101, 1'b0, 1'b0, gnt(2, 1'b0, "W_long_stall_a"));
        cyc(1'b1, 5'b00101, 1'b0, 1'b0, gnt(2, 1'b0, "W_long_stall_b"));
      end
    end
    cyc(1'b1, 5'b00101, 1'b0, 1'b1, gnt(0, 1'b1, "forced_release_err"));
    cyc(1'b1, 5'b00000, 1'b1, 1'b1, none("err_one_cycle"));

    // ptr=1: tail on the 16th flit is a normal release with no err.
    cyc(1'b1, 5'b00010, 1'b0, 1'b1, gnt(1, 1'b0, "S_long_grant"));
    for (int i = 1; i <= 15; i++)
      cyc(1'b1, 5'b00000, 1'b0, 1'b1, gnt(1, 1'b0, $sformatf("S_long_acc_%0d", i)));
    cyc(1'b1, 5'b00000, 1'b1, 1'b1, none("tail_at_max_no_err"));

    // ptr=2: E granted, reset mid-packet drops it and restores N priority.
    cyc(1'b1, 5'b01000, 1'b0, 1'b1, gnt(3, 1'b0, "E_grant_pre_reset"));
    cyc(1'b0, 5'b11111, 1'b0, 1'b1, none("reset_in_busy"));
    cyc(1'b1, 5'b11111, 1'b0, 1'b1, gnt(0, 1'b0, "N_after_reset"));
    cyc(1'b1, 5'b00000, 1'b1, 1'b1, none("N_release"));

    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
